// File: rtl/crc_append.sv
// Serial USB CRC appender: forwards payload bits, then appends CRC5 (TOKEN) or CRC16 (DATA).
// Latency 1 cycle, all outputs registered; pause stalls sampling and emission for that cycle.
module crc_append #(
  parameter logic [4:0]  CRC5_POLY  = 5'b00101,
  parameter logic [15:0] CRC16_POLY = 16'h8005,
  parameter int unsigned MAX_BITS   = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pkt_in,
  input  logic       s_in,
  input  logic       endr,
  input  logic       pause,
  output logic       s_out,
  output logic       out_valid,
  output logic       start_b,
  output logic       endb,
  output logic       busy,
  output logic       len_err
);

  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BITS - 1);

  localparam logic [1:0] PKT_TOKEN = 2'b01;
  localparam logic [1:0] PKT_HS    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    ccnt_q, ccnt_d;
  logic          first_q, first_d;
  logic          s_out_q, s_out_d;
  logic          out_valid_q, out_valid_d;
  logic          start_b_q, start_b_d;
  logic          endb_q, endb_d;
  logic          busy_q, busy_d;
  logic          len_err_q, len_err_d;

  logic is5;
  logic crc_msb;

  assign is5     = (mode_q == PKT_TOKEN);
  assign crc_msb = is5 ? lfsr_q[4] : lfsr_q[15];

  // Feeding the current MSB back in as din gives fb=0, i.e. the plain shift used while emitting CRC.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input logic din,
                                            input logic sel5);
    logic        fb;
    logic [15:0] nxt;
    if (sel5) begin
      fb  = din ^ cur[4];
      nxt = {11'd0, cur[3:0], 1'b0} ^ (fb ? {11'd0, CRC5_POLY} : 16'd0);
    end else begin
      fb  = din ^ cur[15];
      nxt = {cur[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'd0);
    end
    return nxt;
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lfsr_d      = lfsr_q;
    bcnt_d      = bcnt_q;
    ccnt_d      = ccnt_q;
    first_d     = first_q;
    s_out_d     = s_out_q;
    out_valid_d = 1'b0;
    start_b_d   = 1'b0;
    endb_d      = 1'b0;
    len_err_d   = len_err_q;

    case (state_q)
      S_IDLE: begin
        if (pkt_in != 2'b00) begin
          mode_d    = pkt_in;
          lfsr_d    = (pkt_in == PKT_TOKEN) ? 16'h001F : 16'hFFFF;
          bcnt_d    = '0;
          len_err_d = 1'b0;
          first_d   = 1'b1;
          if (!endr) begin
            state_d = S_DATA;
          end else if (pkt_in != PKT_HS) begin
            state_d = S_CRC;
            ccnt_d  = (pkt_in == PKT_TOKEN) ? 4'd4 : 4'd15;
          end
        end
      end

      S_DATA: begin
        if (!pause) begin
          lfsr_d      = lfsr_step(lfsr_q, s_in, is5);
          s_out_d     = s_in;
          out_valid_d = 1'b1;
          start_b_d   = first_q;
          first_d     = 1'b0;
          if (bcnt_q != CNT_MAX) bcnt_d = bcnt_q + 1'b1;
          // Overflow is flagged once the MAX_BITS-th bit is taken and more are still coming.
          if (!endr && bcnt_q >= CNT_LAST) len_err_d = 1'b1;
          if (endr) begin
            if (mode_q == PKT_HS) begin
              endb_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_CRC;
              ccnt_d  = is5 ? 4'd4 : 4'd15;
            end
          end
        end
      end

      S_CRC: begin
        if (!pause) begin
          s_out_d     = ~crc_msb;
          out_valid_d = 1'b1;
          start_b_d   = first_q;
          first_d     = 1'b0;
          lfsr_d      = lfsr_step(lfsr_q, crc_msb, is5);
          if (ccnt_q == 4'd0) begin
            endb_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ccnt_d = ccnt_q - 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      lfsr_q      <= 16'd0;
      bcnt_q      <= '0;
      ccnt_q      <= 4'd0;
      first_q     <= 1'b0;
      s_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      start_b_q   <= 1'b0;
      endb_q      <= 1'b0;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      bcnt_q      <= bcnt_d;
      ccnt_q      <= ccnt_d;
      first_q     <= first_d;
      s_out_q     <= s_out_d;
      out_valid_q <= out_valid_d;
      start_b_q   <= start_b_d;
      endb_q      <= endb_d;
      busy_q      <= busy_d;
      len_err_q   <= len_err_d;
    end
  end

  assign s_out     = s_out_q;
  assign out_valid = out_valid_q;
  assign start_b   = start_b_q;
  assign endb      = endb_q;
  assign busy      = busy_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_crc_append.sv
// Directed bench for crc_append: TOKEN/DATA/HANDSHAKE framing, pause, reset abort, overflow.
module tb_crc_append;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic [1:0] pkt_in = 2'b00;
  logic       s_in   = 1'b0;
  logic       endr   = 1'b0;
  logic       pause  = 1'b0;
  logic       s_out, out_valid, start_b, endb, busy, len_err;

  crc_append #(.MAX_BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pkt_in   (pkt_in),
    .s_in     (s_in),
    .endr     (endr),
    .pause    (pause),
    .s_out    (s_out),
    .out_valid(out_valid),
    .start_b  (start_b),
    .endb     (endb),
    .busy     (busy),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] cap_bits;
  int          ncap, sb_cnt, sb_idx, eb_cnt, eb_idx, busy_cyc, pz_bad;
  logic        pz_chk    = 1'b0;
  logic        last_sout = 1'b0;
  logic [7:0]  hs_pat    = 8'b1011_0100;
  logic [19:0] ov_pat    = 20'h80001;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_cap();
    cap_bits = 64'd0;
    ncap     = 0;
    sb_cnt   = 0;
    sb_idx   = -1;
    eb_cnt   = 0;
    eb_idx   = -1;
    busy_cyc = 0;
    pz_bad   = 0;
  endtask

  // Inputs change on the falling edge; outputs of the following rising edge are logged on the next falling edge.
  task automatic step(input logic [1:0] p, input logic s, input logic e, input logic pz);
    pkt_in = p;
    s_in   = s;
    endr   = e;
    pause  = pz;
    @(negedge clk);
    if (start_b) begin sb_cnt++; sb_idx = ncap; end
    if (endb)    begin eb_cnt++; eb_idx = ncap; end
    if (out_valid) begin
      cap_bits = {cap_bits[62:0], s_out};
      ncap++;
    end
    if (busy) busy_cyc++;
    if (pz_chk) begin
      if (out_valid !== !pz) pz_bad++;
      if (pz && (s_out !== last_sout)) pz_bad++;
    end
    last_sout = s_out;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy || out_valid) && n < 200) begin
      step(2'b00, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check({tag, "_drain"}, 64'(busy || out_valid), 64'd0);
  endtask

  task automatic check_pkt(input string tag, input logic [63:0] exp_bits, input int exp_n);
    check({tag, "_bits"},   cap_bits,     exp_bits);
    check({tag, "_nbits"},  64'(ncap),    64'(exp_n));
    check({tag, "_sb_cnt"}, 64'(sb_cnt),  64'd1);
    check({tag, "_sb_idx"}, 64'(sb_idx),  64'd0);
    check({tag, "_eb_cnt"}, 64'(eb_cnt),  64'd1);
    check({tag, "_eb_idx"}, 64'(eb_idx),  64'(exp_n - 1));
  endtask

  task automatic tok_run();
    step(2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) step(2'b00, 1'b0, (i == 11), 1'b0);
    drain("tok");
  endtask

  initial begin
    clr_cap();

    // Reset state
    #1 rst_n = 1'b0;
    #2 check("reset_outs", 64'({s_out, out_valid, start_b, endb, busy, len_err}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // TOKEN, 11 zero bits: CRC5 bits 0,1,0,0,0
    clr_cap();
    tok_run();
    check_pkt("tok", 64'h0008, 16);
    check("tok_idle", 64'(busy), 64'd0);

    // DATA, zero-length (s_in=1 on the accept cycle must be ignored)
    clr_cap();
    step(2'b10, 1'b1, 1'b1, 1'b0);
    drain("dz");
    check_pkt("dz", 64'd0, 16);
    check("dz_busy_cyc", 64'(busy_cyc), 64'd16);

    // HANDSHAKE, 8 bits forwarded, no CRC
    clr_cap();
    step(2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) step(2'b00, hs_pat[i], (i == 0), 1'b0);
    drain("hs");
    check_pkt("hs", 64'hB4, 8);
    check("hs_idle", 64'(busy), 64'd0);

    // HANDSHAKE, zero-length: nothing emitted, never busy
    clr_cap();
    step(2'b11, 1'b1, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    check("hs0_nbits", 64'(ncap), 64'd0);
    check("hs0_busy_cyc", 64'(busy_cyc), 64'd0);

    // TOKEN with pauses in payload (incl. endr cycle), on CRC bit 3 and the last CRC bit; stray pkt_in ignored
    clr_cap();
    step(2'b01, 1'b0, 1'b0, 1'b0);
    pz_chk = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 4)  step(2'b00, 1'b1, 1'b0, 1'b1);
      if (i == 11) step(2'b00, 1'b1, 1'b1, 1'b1);
      step((i == 6) ? 2'b10 : 2'b00, 1'b0, (i == 11), 1'b0);
    end
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    pz_chk = 1'b0;
    drain("tokp");
    check_pkt("tokp", 64'h0008, 16);
    check("tokp_pause_slots", 64'(pz_bad), 64'd0);

    // Reset during CRC bit 2 of a DATA packet
    clr_cap();
    step(2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    check("rst_pre_nbits", 64'(ncap), 64'd6);
    #2 rst_n = 1'b0;
    #1 check("rst_outs", 64'({s_out, out_valid, start_b, endb, busy, len_err}), 64'd0);
    @(negedge clk);
    check("rst_hold_outs", 64'({out_valid, endb, busy}), 64'd0);
    rst_n = 1'b1;
    clr_cap();
    tok_run();
    check_pkt("rst_tok", 64'h0008, 16);

    // Overflow with MAX_BITS=16: 20-bit DATA payload, CRC16 still appended
    clr_cap();
    step(2'b10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(2'b00, ov_pat[19-i], (i == 19), 1'b0);
      if (i == 14) check("ov_len_err_b15", 64'(len_err), 64'd0);
      if (i == 16) check("ov_len_err_b17", 64'(len_err), 64'd1);
    end
    drain("ov");
    check_pkt("ov", 64'h0000_0008_0001_7FBA, 36);
    check("ov_len_err_sticky", 64'(len_err), 64'd1);

    // Next accepted pkt_in clears len_err
    clr_cap();
    step(2'b01, 1'b0, 1'b0, 1'b0);
    check("ov_len_err_clr", 64'(len_err), 64'd0);
    for (int i = 1; i <= 11; i++) step(2'b00, 1'b0, (i == 11), 1'b0);
    drain("tok3");
    check_pkt("tok3", 64'h0008, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_append.md
CRC_APPEND -- requirements
Module: crc_append

Interface
REQ-001 Parameter CRC5_POLY, default 5'b00101, meaning: CRC5 generator polynomial, x^5 term implicit.
REQ-002 Parameter CRC16_POLY, default 16'h8005, meaning: CRC16 generator polynomial, x^16 term implicit.
REQ-003 Parameter MAX_BITS, default 8192, meaning: maximum payload length in bits; payload counter width is $clog2(MAX_BITS+1).
REQ-004 Port clk, input, 1 bit: single clock, rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port pkt_in, input, 2 bits: packet-start pulse and mode; 2'b01 TOKEN (CRC5), 2'b10 DATA (CRC16), 2'b11 HANDSHAKE (no CRC), 2'b00 none.
REQ-007 Port s_in, input, 1 bit: serial payload bit, USB wire order.
REQ-008 Port endr, input, 1 bit: marks the current s_in as the last payload bit.
REQ-009 Port pause, input, 1 bit: downstream stall (bit-stuff slot); the block takes no bit and emits no bit this cycle.
REQ-010 Port s_out, output, 1 bit: serial output, payload followed by CRC.
REQ-011 Port out_valid, output, 1 bit: s_out carries a new bit this cycle.
REQ-012 Port start_b, output, 1 bit: high with the first valid output bit of a packet.
REQ-013 Port endb, output, 1 bit: high with the last valid output bit of a packet.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port len_err, output, 1 bit: sticky payload-overflow flag, cleared only by the next accepted pkt_in.

Function
REQ-016 States: IDLE, DATA, CRC. All outputs are registered.
REQ-017 In IDLE, a nonzero pkt_in is accepted: mode latched, LFSR set to all ones (width 5 or 16 by mode), bit counter cleared, len_err cleared, next state DATA.
REQ-018 A nonzero pkt_in in DATA or CRC is ignored; a pkt_in of 2'b00 in IDLE is ignored.
REQ-019 In DATA with pause=0, s_in is sampled and presented on s_out with out_valid=1 one cycle later, so the fixed latency is 1 cycle.
REQ-020 LFSR update per sampled bit: fb = s_in ^ lfsr[MSB]; lfsr = {lfsr[MSB-1:0],0} ^ (fb ? POLY : 0).
REQ-021 start_b is asserted with the first out_valid after acceptance, for exactly one cycle.
REQ-022 With pause=1, there is no sample, no LFSR or counter change, and no state change; endr is ignored; out_valid=0 on the next cycle; s_out holds its last value.
REQ-023 endr=1 with pause=0 in DATA: the bit is processed normally; TOKEN or DATA mode moves to CRC; HANDSHAKE mode asserts endb with that bit's output and returns to IDLE.
REQ-024 In CRC, one bit per unpaused cycle: s_out = ~lfsr[MSB], LFSR shifts left filling 0, down-counter runs from W-1 to 0, with W = 5 or 16.
REQ-025 endb is asserted with the final CRC bit (counter 0), then the block returns to IDLE.
REQ-026 The CRC state follows the final payload bit with no gap cycle; unpaused output is contiguous.
REQ-027 pkt_in accepted with endr=1 in the same cycle gives a zero-length payload: that cycle's s_in is ignored, the next state is CRC directly, and start_b falls on the first CRC bit. HANDSHAKE in this case emits nothing and stays in IDLE.
REQ-028 When the bit counter reaches MAX_BITS with no endr, len_err is set, further s_in is still forwarded, the counter saturates, and the CRC is still appended on endr.
REQ-029 pause may be asserted in any state and on any cycle, including the endr cycle and the final CRC cycle; the sequence resumes unchanged.

Reset
REQ-030 While rst_n=0, the state is IDLE, LFSR and counters are 0, s_out=0, out_valid=0, start_b=0, endb=0, busy=0, len_err=0.
REQ-031 Reset asserted mid-packet aborts immediately with no endb; after release the block accepts a new pkt_in on the first clk edge.

Verification
REQ-032 TOKEN, 11 zero bits, endr on the 11th -> 11 zeros then CRC bits 0,1,0,0,0; start_b on bit 1, endb on bit 16.
REQ-033 DATA with zero-length payload (pkt_in=2'b10 with endr) -> 16 zero CRC bits, start_b on the first, endb on the 16th, busy for 16 cycles.
REQ-034 HANDSHAKE, 8 bits 10110100 -> same 8 bits delayed 1 cycle, endb on the 8th, no CRC bits, then IDLE.
REQ-035 The REQ-032 sequence with pause pulsed during payload and during CRC bit 3 -> identical output bit stream, out_valid low exactly in the paused slots.
REQ-036 rst_n pulsed low during CRC bit 2 of a DATA packet -> all outputs 0 asynchronously, no endb; the next TOKEN gives the REQ-032 result.
REQ-037 MAX_BITS=16, DATA with 20 bits -> len_err rises after bit 16, all 20 bits are forwarded, the 16-bit CRC is appended, and len_err clears at the next pkt_in.
